// File: rtl/fft_mag_stream.sv
// Streaming N-point radix-2 DIT FFT: loads real samples, runs one butterfly per cycle, then streams re^2+im^2 per bin.
// Define FFT_MAG_STREAM_STAGE_SCALE_EN to halve every butterfly output (overall 1/N scaling).
`timescale 1ns/1ps
module fft_mag_stream #(
  parameter int sample_size   = 32,
  parameter int buffer_size   = 32,
  parameter int twiddle_size  = 16,
  parameter int no_float_mult = 1000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [sample_size-1:0] in_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [sample_size-1:0] out_mag,
  output logic                          out_last,
  output logic                          busy
);
  localparam int LG  = $clog2(buffer_size);
  localparam int LG1 = LG - 1;
  localparam int HN  = buffer_size / 2;
  localparam int DW  = sample_size + LG + 1;
  localparam int PW  = DW + twiddle_size + 1;
  localparam int SW  = 2 * DW + 1;
  localparam logic signed [PW-1:0] NFM = PW'(no_float_mult);

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  // cos(2*pi*m/64) * 1e9 over one quarter wave; any N up to 64 indexes into it.
  function automatic longint q64(input int m);
    case (m)
      0:  q64 = 64'd1000000000;  1:  q64 = 64'd995184727;
      2:  q64 = 64'd980785280;   3:  q64 = 64'd956940336;
      4:  q64 = 64'd923879533;   5:  q64 = 64'd881921264;
      6:  q64 = 64'd831469612;   7:  q64 = 64'd773010453;
      8:  q64 = 64'd707106781;   9:  q64 = 64'd634393284;
      10: q64 = 64'd555570233;   11: q64 = 64'd471396737;
      12: q64 = 64'd382683432;   13: q64 = 64'd290284677;
      14: q64 = 64'd195090322;   15: q64 = 64'd98017140;
      default: q64 = 64'd0;
    endcase
  endfunction

  function automatic longint tw_cos(input int k);
    int j;
    j = k * (64 / buffer_size);
    tw_cos = (j <= 16) ? q64(j) : -q64(32 - j);
  endfunction

  function automatic longint tw_sin(input int k);
    int j;
    j = k * (64 / buffer_size);
    tw_sin = (j <= 16) ? q64(16 - j) : q64(j - 16);
  endfunction

  // round(v * no_float_mult / 1e9), halves away from zero
  function automatic longint scale_round(input longint v);
    longint p;
    p = v * longint'(no_float_mult);
    scale_round = (p >= 0) ? (p + 500000000) / 1000000000 : -((500000000 - p) / 1000000000);
  endfunction

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] v);
    for (int i = 0; i < LG; i++) bitrev[i] = v[LG-1-i];
  endfunction

  logic signed [twiddle_size-1:0] tw_re [HN];
  logic signed [twiddle_size-1:0] tw_im [HN];
  for (genvar g = 0; g < HN; g++) begin : g_tw
    assign tw_re[g] = twiddle_size'(scale_round(tw_cos(g)));
    assign tw_im[g] = twiddle_size'(scale_round(tw_sin(g)));
  end

  logic [1:0]           state;
  logic [LG-1:0]        ld_cnt;
  logic [LG-1:0]        bin;
  logic [LG1-1:0]       bfly;
  logic [2:0]           stage;
  logic signed [DW-1:0] re_m [buffer_size];
  logic signed [DW-1:0] im_m [buffer_size];

  logic [LG-1:0]                  pos, ia, ib;
  logic [LG1-1:0]                 tk;
  logic signed [twiddle_size-1:0] wc, ws;
  logic signed [DW-1:0]           a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [DW-1:0]           x_re, x_im, y_re, y_im;
  logic signed [PW-1:0]           p_re, p_im;

  // Butterfly ia/ib = a, b; twiddle W = cos - j*sin, so b*W = (br*c + bi*s) + j(bi*c - br*s).
  always_comb begin
    pos  = LG'(bfly) & ((LG'(1) << stage) - LG'(1));
    ia   = ((LG'(bfly) >> stage) << (stage + 3'd1)) | pos;
    ib   = ia | (LG'(1) << stage);
    tk   = LG1'(pos << (LG1 - int'(stage)));
    wc   = tw_re[tk];
    ws   = tw_im[tk];
    a_re = re_m[ia];
    a_im = im_m[ia];
    b_re = re_m[ib];
    b_im = im_m[ib];
    p_re = PW'(b_re) * PW'(wc) + PW'(b_im) * PW'(ws);
    p_im = PW'(b_im) * PW'(wc) - PW'(b_re) * PW'(ws);
    t_re = DW'(p_re / NFM);
    t_im = DW'(p_im / NFM);
`ifdef FFT_MAG_STREAM_STAGE_SCALE_EN
    x_re = (a_re + t_re) >>> 1;
    x_im = (a_im + t_im) >>> 1;
    y_re = (a_re - t_re) >>> 1;
    y_im = (a_im - t_im) >>> 1;
`else
    x_re = a_re + t_re;
    x_im = a_im + t_im;
    y_re = a_re - t_re;
    y_im = a_im - t_im;
`endif
  end

  logic signed [SW-1:0] m_re, m_im;
  logic        [SW-1:0] msum;

  always_comb begin
    m_re = SW'(re_m[bin]);
    m_im = SW'(im_m[bin]);
    msum = SW'(m_re * m_re) + SW'(m_im * m_im);
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state == COMPUTE) || (state == OUTPUT);
  assign out_last  = out_valid && (bin == LG'(buffer_size - 1));
  assign out_mag   = !out_valid ? '0 :
                     (|msum[SW-1:sample_size]) ? '1 : msum[sample_size-1:0];

  always_ff @(posedge clk) begin
    if (reset_n && state == LOAD && in_valid) begin
      re_m[bitrev(ld_cnt)] <= DW'(in_sample);
      im_m[bitrev(ld_cnt)] <= '0;
    end else if (reset_n && state == COMPUTE) begin
      re_m[ia] <= x_re;
      im_m[ia] <= x_im;
      re_m[ib] <= y_re;
      im_m[ib] <= y_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= LOAD;
      ld_cnt <= '0;
      bin    <= '0;
      bfly   <= '0;
      stage  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            ld_cnt <= ld_cnt + LG'(1);
            if (ld_cnt == LG'(buffer_size - 1)) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          bfly <= bfly + LG1'(1);
          if (bfly == LG1'(HN - 1)) begin
            if (stage == 3'(LG - 1)) begin
              stage <= '0;
              state <= OUTPUT;
            end else begin
              stage <= stage + 3'd1;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            bin <= bin + LG'(1);
            if (bin == LG'(buffer_size - 1)) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_mag_stream.sv
// Directed bench for fft_mag_stream at N=8; expected bins are hand-derived for both scaling builds.
`timescale 1ns/1ps
module tb_fft_mag_stream;
  localparam int N = 8;

`ifdef FFT_MAG_STREAM_STAGE_SCALE_EN
  localparam logic [31:0] IMP_MAG  = 32'd15625;
  localparam logic [31:0] DC_MAG   = 32'd10000;
  localparam logic [31:0] COS_PEAK = 32'd249001;
  localparam logic [31:0] COS_ODD  = 32'd0;
`else
  localparam logic [31:0] IMP_MAG  = 32'd1000000;
  localparam logic [31:0] DC_MAG   = 32'd640000;
  localparam logic [31:0] COS_PEAK = 32'd15992001;
  localparam logic [31:0] COS_ODD  = 32'd1;
`endif

  logic               clk = 1'b0;
  logic               reset_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [31:0] in_sample;
  logic        [31:0] out_mag;
  int                 vectors = 0;
  int                 miscompares = 0;

  fft_mag_stream #(
    .sample_size(32), .buffer_size(N), .twiddle_size(16), .no_float_mult(1000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Loads one frame, waits for OUTPUT, drains all bins (optionally with a 1,0,0,1 ready pattern).
  task automatic run_frame(input int smp[N], input bit stall, input bit junk,
                           output logic [31:0] mag[N], output logic lst[N],
                           output int busy_cnt, output int hold_err, output int proto_err,
                           output bit tmo, output logic post_rdy, output logic post_vld);
    int k, cyc, ph;
    logic [31:0] held_mag;
    logic held_last;
    bit stalled;
    k = 0; cyc = 0; ph = 0; stalled = 0; tmo = 0;
    busy_cnt = 0; hold_err = 0; proto_err = 0;
    held_mag = '0; held_last = 1'b0;
    for (int i = 0; i < N; i++) begin mag[i] = '0; lst[i] = 1'b0; end
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = smp[i];
    end
    @(negedge clk);
    in_valid  = junk;
    in_sample = 32'sd54321;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busy_cnt++;
      if (in_ready !== 1'b0) proto_err++;
      @(negedge clk);
      cyc++;
    end
    while (k < N && cyc < 400) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) proto_err++;
      if (stalled && (out_mag !== held_mag || out_last !== held_last)) hold_err++;
      out_ready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      if (out_ready) begin
        mag[k] = out_mag;
        lst[k] = out_last;
        k++;
        stalled = 0;
      end else begin
        stalled   = 1;
        held_mag  = out_mag;
        held_last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    tmo       = (k < N);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    post_rdy  = in_ready;
    post_vld  = out_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sample = '0;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_mag !== 32'd0) begin miscompares++; $display("FAIL reset_out_mag: got %0d want 0", out_mag); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_impulse();
    int smp[N];
    logic [31:0] mag[N];
    logic lst[N];
    int bc, he, pe;
    bit tmo;
    logic prdy, pvld;
    smp = '{1000, 0, 0, 0, 0, 0, 0, 0};
    run_frame(smp, 0, 0, mag, lst, bc, he, pe, tmo, prdy, pvld);
    vectors++; if (tmo) begin miscompares++; $display("FAIL impulse_timeout: frame did not complete"); end
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (mag[k] !== IMP_MAG) begin miscompares++; $display("FAIL impulse_bin%0d: got %0d want %0d", k, mag[k], IMP_MAG); end
      vectors++;
      if (lst[k] !== (k == N - 1)) begin miscompares++; $display("FAIL impulse_last%0d: got %b want %b", k, lst[k], k == N - 1); end
    end
    vectors++; if (prdy !== 1'b1) begin miscompares++; $display("FAIL impulse_post_in_ready: got %b want 1", prdy); end
    vectors++; if (pvld !== 1'b0) begin miscompares++; $display("FAIL impulse_post_out_valid: got %b want 0", pvld); end
  endtask

  task automatic test_dc();
    int smp[N];
    logic [31:0] mag[N];
    logic lst[N];
    int bc, he, pe;
    bit tmo;
    logic prdy, pvld;
    smp = '{100, 100, 100, 100, 100, 100, 100, 100};
    run_frame(smp, 0, 0, mag, lst, bc, he, pe, tmo, prdy, pvld);
    vectors++; if (tmo) begin miscompares++; $display("FAIL dc_timeout: frame did not complete"); end
    vectors++; if (bc !== 12) begin miscompares++; $display("FAIL dc_compute_cycles: got %0d want 12", bc); end
    vectors++; if (pe !== 0) begin miscompares++; $display("FAIL dc_protocol: got %0d errors want 0", pe); end
    vectors++; if (mag[0] !== DC_MAG) begin miscompares++; $display("FAIL dc_bin0: got %0d want %0d", mag[0], DC_MAG); end
    for (int k = 1; k < N; k++) begin
      vectors++;
      if (mag[k] !== 32'd0) begin miscompares++; $display("FAIL dc_bin%0d: got %0d want 0", k, mag[k]); end
    end
  endtask

  task automatic check_cosine(input string tag, input bit stall);
    int smp[N];
    logic [31:0] mag[N];
    logic [31:0] exp_mag;
    logic lst[N];
    int bc, he, pe;
    bit tmo;
    logic prdy, pvld;
    smp = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    run_frame(smp, stall, stall, mag, lst, bc, he, pe, tmo, prdy, pvld);
    vectors++; if (tmo) begin miscompares++; $display("FAIL %s_timeout: frame did not complete", tag); end
    vectors++; if (he !== 0) begin miscompares++; $display("FAIL %s_hold: got %0d unstable stalls want 0", tag, he); end
    vectors++; if (pe !== 0) begin miscompares++; $display("FAIL %s_protocol: got %0d errors want 0", tag, pe); end
    for (int k = 0; k < N; k++) begin
      exp_mag = (k == 1 || k == 7) ? COS_PEAK : (k == 3 || k == 5) ? COS_ODD : 32'd0;
      vectors++;
      if (mag[k] !== exp_mag) begin miscompares++; $display("FAIL %s_bin%0d: got %0d want %0d", tag, k, mag[k], exp_mag); end
      vectors++;
      if (lst[k] !== (k == N - 1)) begin miscompares++; $display("FAIL %s_last%0d: got %b want %b", tag, k, lst[k], k == N - 1); end
    end
  endtask

  task automatic test_cosine();
    check_cosine("cosine", 0);
  endtask

  task automatic test_back_to_back_stall();
    check_cosine("stall", 1);
  endtask

  task automatic test_reset_midframe();
    int smp[N];
    logic [31:0] mag[N];
    logic lst[N];
    int bc, he, pe;
    bit tmo;
    logic prdy, pvld;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 32'sd100;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midreset_in_compute: got busy %b want 1", busy); end
    reset_n = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
    vectors++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_mag !== 32'd0) begin
      miscompares++; $display("FAIL midreset_outputs: got valid %b last %b mag %0d want 0 0 0", out_valid, out_last, out_mag);
    end
    reset_n = 1'b1;
    smp = '{100, 100, 100, 100, 100, 100, 100, 100};
    run_frame(smp, 0, 0, mag, lst, bc, he, pe, tmo, prdy, pvld);
    vectors++; if (tmo) begin miscompares++; $display("FAIL midreset_timeout: frame did not complete"); end
    vectors++; if (mag[0] !== DC_MAG) begin miscompares++; $display("FAIL midreset_bin0: got %0d want %0d", mag[0], DC_MAG); end
    vectors++; if (mag[1] !== 32'd0) begin miscompares++; $display("FAIL midreset_bin1: got %0d want 0", mag[1]); end
    vectors++; if (bc !== 12) begin miscompares++; $display("FAIL midreset_compute_cycles: got %0d want 12", bc); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_cosine();
    test_back_to_back_stall();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
